// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC register feeding a 2-entry in-order buffer
// of {instr, pc} pairs toward decode, with redirect flush and a sticky misalignment flag.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign_err
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] h_instr_q, h_instr_d;
  logic [31:0] h_pc_q, h_pc_d;
  logic [31:0] t_instr_q, t_instr_d;
  logic [31:0] t_pc_q, t_pc_d;
  logic [1:0]  count_q, count_d;
  logic        mis_q, mis_d;
  logic        deq_s;
  logic        enq_s;

  // Handshake decode and next-state for PC, buffer slots (head = oldest) and flag
  always_comb begin
    fpc_d     = fpc_q;
    h_instr_d = h_instr_q;
    h_pc_d    = h_pc_q;
    t_instr_d = t_instr_q;
    t_pc_d    = t_pc_q;
    count_d   = count_q;
    mis_d     = mis_q;
    deq_s     = (count_q != 2'd0) && out_ready && !redirect_valid;
    enq_s     = !redirect_valid && ((count_q != 2'd2) || deq_s);

    if (redirect_valid) begin
      count_d = 2'd0;
      fpc_d   = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end else begin
        mis_d = mis_q;
      end
    end else begin
      case ({enq_s, deq_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            h_instr_d = imem_data;
            h_pc_d    = fpc_q;
          end else begin
            t_instr_d = imem_data;
            t_pc_d    = fpc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          h_instr_d = t_instr_q;
          h_pc_d    = t_pc_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push keeps the occupancy unchanged
          if (count_q == 2'd1) begin
            h_instr_d = imem_data;
            h_pc_d    = fpc_q;
          end else begin
            h_instr_d = t_instr_q;
            h_pc_d    = t_pc_q;
            t_instr_d = imem_data;
            t_pc_d    = fpc_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
      if (enq_s) begin
        fpc_d = fpc_q + 32'd4;
      end else begin
        fpc_d = fpc_q;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_q     <= RESET_PC;
      h_instr_q <= 32'd0;
      h_pc_q    <= 32'd0;
      t_instr_q <= 32'd0;
      t_pc_q    <= 32'd0;
      count_q   <= 2'd0;
      mis_q     <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      h_instr_q <= h_instr_d;
      h_pc_q    <= h_pc_d;
      t_instr_q <= t_instr_d;
      t_pc_q    <= t_pc_d;
      count_q   <= count_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_addr    = {2'b00, fpc_q[31:2]};
  assign out_valid    = (count_q != 2'd0);
  assign out_instr    = h_instr_q;
  assign out_pc       = h_pc_q;
  assign out_pc_plus4 = h_pc_q + 32'd4;
  assign misalign_err = mis_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_addr  output  32  word index to instruction memory, equal to {2'b00, fpc[31:2]}.
REQ-005 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; load redirect_pc this cycle.
REQ-007 redirect_pc  input  32  byte target address of the redirect.
REQ-008 out_valid  output  1  head of the fetch buffer holds a valid instruction.
REQ-009 out_ready  input  1  decode accepts the head entry this cycle.
REQ-010 out_instr  output  32  instruction word at the buffer head.
REQ-011 out_pc  output  32  byte address of out_instr.
REQ-012 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-013 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-014 The block SHALL hold the fetch PC register fpc (32 bits) and a 2-entry FIFO of {instr, pc} pairs, with count 0..2.
REQ-015 out_valid SHALL equal (count != 0), and out_instr/out_pc SHALL come from the oldest entry.
REQ-016 A dequeue SHALL occur on an edge when out_valid && out_ready && !redirect_valid.
REQ-017 An enqueue of {imem_data, fpc} SHALL occur on an edge when !redirect_valid and (count < 2 or a dequeue occurs that edge); on enqueue, fpc <= fpc + 4.
REQ-018 With count == 2 and a dequeue on the same edge, the block SHALL enqueue in that edge and count SHALL stay 2.
REQ-019 With count == 2 and no dequeue, fpc and the FIFO SHALL hold, and imem_addr SHALL stay stable.
REQ-020 With count == 0, out_valid SHALL be 0, out_ready SHALL be ignored, and no dequeue SHALL occur.
REQ-021 On redirect_valid at an edge, the block SHALL flush the FIFO (count <= 0), set fpc <= {redirect_pc[31:2], 2'b00}, and enqueue and dequeue nothing; redirect takes priority over every other event.
REQ-022 If redirect_valid && redirect_pc[1:0] != 0 at an edge, misalign_err SHALL be set to 1 and stay 1 until reset.
REQ-023 fpc increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; out_pc_plus4 SHALL wrap the same way.
REQ-024 Latency: an instruction enqueued at edge N SHALL be visible on out_* after edge N when it is the oldest entry; it SHALL take no extra cycles when the FIFO is empty.
REQ-025 FIFO order SHALL be strictly program order between redirects; no entry SHALL be duplicated or dropped except by flush.
REQ-026 imem_addr SHALL depend only on fpc, with no combinational path from out_ready or redirect_* to imem_addr.

Reset
REQ-027 When reset_n = 0, regardless of clk, fpc SHALL be RESET_PC, count 0, out_valid 0, and misalign_err 0; out_instr and out_pc SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately; the first enqueue after release SHALL be at the first rising edge with reset_n = 1, from RESET_PC.
REQ-029 Reset release SHALL be synchronous to clk by the integrator; the block needs no internal synchronizer.

Verification
REQ-030 Reset with RESET_PC = 0, memory word0 = 32'h2008_0005, out_ready = 1 -> after the first edge, out_valid = 1, out_instr = 32'h2008_0005, out_pc = 0, out_pc_plus4 = 4; then pc 4, 8, ... follow on successive edges.
REQ-031 out_ready = 0 for 5 edges after reset -> count saturates at 2, imem_addr holds 2 (fpc = 8), and out_pc stays 0; raise out_ready -> out_pc sequence 0, 4, 8 with no gaps or duplicates.
REQ-032 FIFO full, redirect_valid = 1 with redirect_pc = 32'h0000_0040 together with out_ready = 1 -> the next cycle has out_valid = 0 and imem_addr = 16; the edge after that gives out_pc = 32'h40.
REQ-033 Redirect to 32'h0000_0042 -> misalign_err = 1, and fetch resumes at 32'h40; misalign_err holds through later redirects until reset_n = 0.
REQ-034 Redirect to 32'hFFFF_FFFC with out_ready = 1 -> out_pc_plus4 = 0 at that entry, and the next out_pc = 32'h0000_0000.
REQ-035 Assert reset_n = 0 between edges while count = 2 -> out_valid drops to 0 immediately, without a clock edge; after release, the fetch restarts at RESET_PC.
